// File: rtl/waterfall_pkg.sv
// Shared definitions for the waterfall key controller.
//  - press_state_t : encoding of the start-button press FSM
//  - FREQ_*        : speed codes carried on freq_set (units of waterfall rate)
package waterfall_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // button released, waiting for a press
        S_HELD = 2'd1,   // press accepted, counting hold time
        S_LONG = 2'd2    // long press already reported, waiting for release
    } press_state_t;

    // freq_set codes: 00/01/10/11 -> 1/2/5/10 units
    localparam logic [1:0] FREQ_1U  = 2'b00;
    localparam logic [1:0] FREQ_2U  = 2'b01;
    localparam logic [1:0] FREQ_5U  = 2'b10;
    localparam logic [1:0] FREQ_10U = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// One-bit synchroniser plus debouncer.
//  clk, rst_n   : clock, asynchronous active-low reset
//  din          : raw asynchronous input (already polarity-normalised)
//  stable       : registered debounced level
//  stable_next  : value stable takes at the next clock edge, so the caller can
//                 build a change pulse that lines up with the new level
// A level change is accepted after DEBOUNCE_CYCLES consecutive synchronised
// samples that differ from stable; pin edge to stable change is
// DEBOUNCE_CYCLES+2 clocks (two of them in the synchroniser).
module key_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic stable_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 20'd1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next    = cnt;
        stable_next = stable;
        if (sync2 == stable) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            stable_next = sync2;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            cnt    <= cnt_next;
            stable <= stable_next;
        end
    end

endmodule

// File: rtl/waterfall_key_ctrl.sv
// Input conditioning front-end for the LED waterfall stage.
//  clk, rst_n    : clock, asynchronous active-low reset
//  key_start     : raw start button (asynchronous)
//  sw_freq[1:0]  : raw speed switches (asynchronous)
//  start_pulse   : one-cycle pulse per accepted press
//  long_press    : one-cycle pulse once a press has been held LONG_PRESS_CYCLES
//                  clocks after its start_pulse
//  freq_set[1:0] : debounced speed code
//  freq_changed  : one-cycle pulse in the first cycle freq_set shows a new value
// The press FSM state is the internal signal `state` (press_state_t).
module waterfall_key_ctrl
    import waterfall_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd500_000,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd100_000_000,
    parameter logic        KEY_ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic [1:0] sw_freq,
    output logic       start_pulse,
    output logic       long_press,
    output logic [1:0] freq_set,
    output logic       freq_changed
);

    press_state_t state;
    press_state_t state_next;
    logic [31:0]  hold_cnt;
    logic [31:0]  hold_next;
    logic         start_next;
    logic         long_next;

    logic         key_stable;
    logic         key_stable_next;
    logic [1:0]   freq_stable;
    logic [1:0]   freq_stable_next;
    logic         key_pressed;

    // Normalise so that pressed == 1 from here on.
    assign key_pressed = key_start ^ KEY_ACTIVE_LOW;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_key (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (key_pressed),
        .stable      (key_stable),
        .stable_next (key_stable_next)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freq1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (sw_freq[1]),
        .stable      (freq_stable[1]),
        .stable_next (freq_stable_next[1])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freq0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (sw_freq[0]),
        .stable      (freq_stable[0]),
        .stable_next (freq_stable_next[0])
    );

    assign freq_set = freq_stable;

    // Press FSM: one start_pulse per press, at most one long_press per press.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        start_next = 1'b0;
        long_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_stable) begin
                    start_next = 1'b1;
                    hold_next  = 32'd0;
                    state_next = S_HELD;
                end
            end
            S_HELD: begin
                if (!key_stable) begin
                    state_next = S_IDLE;
                end else if (hold_cnt == LONG_PRESS_CYCLES - 32'd1) begin
                    long_next  = 1'b1;
                    state_next = S_LONG;
                end else begin
                    hold_next = hold_cnt + 32'd1;
                end
            end
            S_LONG: begin
                if (!key_stable) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hold_cnt     <= 32'd0;
            start_pulse  <= 1'b0;
            long_press   <= 1'b0;
            freq_changed <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            start_pulse  <= start_next;
            long_press   <= long_next;
            // Compared against the debouncers' next value so the pulse
            // coincides with the first cycle of the new freq_set.
            freq_changed <= (freq_stable_next != freq_stable);
        end
    end

endmodule

// File: tb/tb_waterfall_key_ctrl.sv
// Self-checking bench for waterfall_key_ctrl (DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20). Expected output events are queued with the clock
// index at which they must appear and are matched by a negedge monitor.
module tb_waterfall_key_ctrl;

    localparam int DB = 4;
    localparam int LP = 20;
    localparam int KEY_LAT  = DB + 3;   // pin edge -> start_pulse
    localparam int FREQ_LAT = DB + 2;   // pin edge -> freq_set / freq_changed

    logic       clk;
    logic       rst_n;
    logic       key_start;
    logic [1:0] sw_freq;
    logic       start_pulse;
    logic       long_press;
    logic [1:0] freq_set;
    logic       freq_changed;

    waterfall_key_ctrl #(
        .DEBOUNCE_CYCLES   (20'd4),
        .LONG_PRESS_CYCLES (32'd20),
        .KEY_ACTIVE_LOW    (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_start    (key_start),
        .sw_freq      (sw_freq),
        .start_pulse  (start_pulse),
        .long_press   (long_press),
        .freq_set     (freq_set),
        .freq_changed (freq_changed)
    );

    // ---------------- clock / reset / cycle index ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] start_q[$];   // expected start_pulse cycle
    logic [31:0] long_q[$];    // expected long_press cycle
    logic [31:0] freq_q[$];    // expected {cycle[29:0], freq_set}

    logic [31:0] last_start = 32'd0;
    logic [31:0] last_freq  = 32'd0;
    logic [1:0]  cur_code   = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (start_pulse) begin
            if (start_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
            else begin
                check("start_cycle", cyc, start_q.pop_front());
                last_start = cyc;
            end
        end
        if (long_press) begin
            if (long_q.size() == 0) check("long_unexpected", 32'd1, 32'd0);
            else check("long_cycle", cyc, long_q.pop_front());
        end
        if (freq_changed) begin
            if (freq_q.size() == 0) check("freq_unexpected", {30'd0, freq_set}, 32'hffff_ffff);
            else begin
                check("freq_change", {cyc[29:0], freq_set}, freq_q.pop_front());
                last_freq = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance n clock edges and settle 2 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int hold, input bit expect_long);
        key_start = 1'b1;
        start_q.push_back(cyc + KEY_LAT);
        if (expect_long) long_q.push_back(cyc + KEY_LAT + LP);
        step(hold);
        key_start = 1'b0;
        step(10);
    endtask

    task automatic set_freq(input logic [1:0] code);
        if (code != cur_code) freq_q.push_back({cyc[29:0] + 30'(FREQ_LAT), code});
        sw_freq  = code;
        cur_code = code;
        step(10);
    endtask

    task automatic drained(input string tag);
        check({tag, "_start_q"}, start_q.size(), 0);
        check({tag, "_long_q"},  long_q.size(),  0);
        check({tag, "_freq_q"},  freq_q.size(),  0);
        check({tag, "_freq_set"}, {30'd0, freq_set}, {30'd0, cur_code});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        key_start = 1'b0;
        sw_freq   = 2'b00;
        #1;
        check("rst_start", {31'd0, start_pulse},  0);
        check("rst_long",  {31'd0, long_press},   0);
        check("rst_freq",  {30'd0, freq_set},     0);
        check("rst_fchg",  {31'd0, freq_changed}, 0);
        step(2);
        rst_n = 1'b1;
        step(3);

        // 1: short press, no long_press
        press(12, 1'b0);
        drained("t1");

        // 2: 3-cycle glitches never get through
        for (int i = 0; i < 40; i++) begin
            key_start = ((i / 3) % 2 == 0);
            step(1);
        end
        key_start = 1'b0;
        step(10);
        drained("t2");

        // 3: long hold -> one start_pulse, one long_press, nothing more
        press(40, 1'b1);
        drained("t3");

        // 4: speed 00 -> 10
        set_freq(2'b10);
        drained("t4");

        // 5: reset while key held and freq_set non-zero
        key_start = 1'b1;
        start_q.push_back(cyc + KEY_LAT);
        step(9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", {31'd0, start_pulse},  0);
        check("mid_rst_long",  {31'd0, long_press},   0);
        check("mid_rst_freq",  {30'd0, freq_set},     0);
        check("mid_rst_fchg",  {31'd0, freq_changed}, 0);
        step(2);
        rst_n = 1'b1;
        freq_q.push_back({cyc[29:0] + 30'(FREQ_LAT), cur_code});
        start_q.push_back(cyc + KEY_LAT);
        step(12);
        key_start = 1'b0;
        step(10);
        drained("t5");

        // 6: press and speed change on the same cycle
        set_freq(2'b00);
        key_start = 1'b1;
        sw_freq   = 2'b01;
        cur_code  = 2'b01;
        start_q.push_back(cyc + KEY_LAT);
        freq_q.push_back({cyc[29:0] + 30'(FREQ_LAT), 2'b01});
        step(12);
        key_start = 1'b0;
        step(10);
        check("t6_offset", last_start - last_freq, 32'd1);
        drained("t6");

        // random presses and speed codes
        for (int i = 0; i < 3; i++) begin
            press($urandom_range(5, 18), 1'b0);
            set_freq(2'($urandom_range(0, 3)));
        end
        drained("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
